// File: rtl/bist_misr_ora.sv
// bist_misr_ora: MISR output response analyser that compacts CUT responses and compares against a golden signature
module bist_misr_ora #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] POLY = 4'b0011,
  parameter logic [WIDTH-1:0] SEED = 4'b0000,
  parameter int NUM_PATTERNS = 8,
  localparam int CW = $clog2(NUM_PATTERNS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             resp_valid,
  input  logic [1:0]       dataIn,
  input  logic [WIDTH-1:0] golden_sig,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [CW-1:0]    pattern_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, CMP, DONE} state_t;
  state_t r_state, w_next_state;
  logic [WIDTH-1:0] r_sig, w_misr, w_d, w_taps;
  logic [CW-1:0] r_cnt;
  logic r_pass, w_start, w_accept, w_last, w_fb;
  assign w_start  = start & (r_state == IDLE || r_state == DONE);
  assign w_accept = resp_valid & (r_state == RUN);
  assign w_last   = w_accept & (r_cnt == CW'(NUM_PATTERNS - 1));
  assign w_d      = WIDTH'(dataIn);
  assign w_fb     = r_sig[WIDTH-1];
  assign w_taps   = {POLY[WIDTH-1:1], 1'b1} & {WIDTH{w_fb}};
  assign w_misr   = {r_sig[WIDTH-2:0], 1'b0} ^ w_taps ^ w_d;
  assign busy        = r_state == RUN || r_state == CMP;
  assign done        = r_state == DONE;
  assign pass        = r_pass;
  assign signature   = r_sig;
  assign pattern_cnt = r_cnt;
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next_state;
  end
  // next state: start from IDLE/DONE, leave RUN on the final beat, CMP is a single cycle
  always_comb begin
    w_next_state = r_state;
    if (w_start) w_next_state = RUN;
    else if (w_last) w_next_state = CMP;
    else if (r_state == CMP) w_next_state = DONE;
  end
  // signature, beat counter and verdict
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig  <= '0;
      r_cnt  <= '0;
      r_pass <= 1'b0;
    end else if (w_start) begin
      r_sig  <= SEED;
      r_cnt  <= '0;
      r_pass <= 1'b0;
    end else if (w_accept) begin
      r_sig <= w_misr;
      r_cnt <= r_cnt + 1'b1;
    end else if (r_state == CMP) begin
      r_pass <= r_sig == golden_sig;
    end
  end
endmodule
